// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode trap and CSR unit for a single-issue core.
//
// Holds mstatus (MIE/MPIE), mie, mip (live view of interrupt inputs), mtvec,
// mepc, mcause and the 64-bit mcycle/minstret counters. Each cycle it looks at
// the retiring instruction and decides whether to take an interrupt, take an
// exception, execute mret, apply a CSR write, or put the core to sleep on WFI.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   instr_valid/pc/next_pc  retiring instruction, its PC and its successor
//   is_ecall/is_ebreak/is_mret/is_wfi/illegal_in  decode flags
//   csr_addr/op/wdata       CSR access (op 00 none, 01 write, 10 set, 11 clear)
//   csr_rdata               combinational old value of csr_addr
//   msip/mtip/meip, irq     interrupt inputs (irq[i] -> mip[16+i])
//   trap_taken              retiring instruction is squashed
//   redirect_valid/pc       fetch redirect; redirect_pc shows next_pc otherwise
//   stall                   core held while sleeping in WFI
//
// Build option: define TRAP_VECTORED_EN to make mtvec mode bit 0 writable and
// send interrupts to base + 4*cause when it is set.
module trap_csr_unit #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  instr_valid,
  input  logic [31:0]                           instr_pc,
  input  logic [31:0]                           next_pc,
  input  logic                                  is_ecall,
  input  logic                                  is_ebreak,
  input  logic                                  is_mret,
  input  logic                                  is_wfi,
  input  logic                                  illegal_in,
  input  logic [11:0]                           csr_addr,
  input  logic [1:0]                            csr_op,
  input  logic [31:0]                           csr_wdata,
  output logic [31:0]                           csr_rdata,
  input  logic                                  msip,
  input  logic                                  mtip,
  input  logic                                  meip,
  input  logic [((NUM_IRQ > 0) ? NUM_IRQ : 1)-1:0] irq,
  output logic                                  trap_taken,
  output logic                                  redirect_valid,
  output logic [31:0]                           redirect_pc,
  output logic                                  stall
);

  typedef enum logic {RUN = 1'b0, SLEEP = 1'b1} state_e;

  // Bits of mip/mie that exist: MSI, MTI, MEI and the platform lines.
  function automatic logic [31:0] int_mask_f();
    logic [31:0] m;
    m = 32'h0000_0888;
    for (int i = 0; i < int'(NUM_IRQ); i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] INT_MASK = int_mask_f();
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  state_e      state_q, state_d;
  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [31:0] mip_w, pending, csr_new, trap_pc;
  logic        csr_impl, valid, int_req, exc, trap, retire, csr_we, mret_ok, wfi_ok;
  logic [4:0]  int_code, exc_code, cause_code;

  always_comb begin
    mip_w     = '0;
    mip_w[3]  = msip;
    mip_w[7]  = mtip;
    mip_w[11] = meip;
    for (int i = 0; i < int'(NUM_IRQ); i++) mip_w[16+i] = irq[i];
  end

  assign pending = mip_w & mie_q;

  // CSR read mux; csr_impl flags addresses that exist.
  always_comb begin
    csr_rdata = '0;
    csr_impl  = 1'b1;
    case (csr_addr)
      12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      12'h304: csr_rdata = mie_q;
      12'h344: csr_rdata = mip_w;
      12'h305: csr_rdata = mtvec_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'hB00: csr_rdata = mcycle_q[31:0];
      12'hB80: csr_rdata = mcycle_q[63:32];
      12'hB02: csr_rdata = minstret_q[31:0];
      12'hB82: csr_rdata = minstret_q[63:32];
      default: csr_impl = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  // Lowest irq index wins among platform lines; MEI > MSI > MTI above them.
  always_comb begin
    int_code = 5'd0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--)
      if (pending[16+i]) int_code = 5'(16 + i);
    if (pending[7])  int_code = 5'd7;
    if (pending[3])  int_code = 5'd3;
    if (pending[11]) int_code = 5'd11;
  end

  // Reset and sleep both hide the retiring instruction from all decisions.
  always_comb begin
    valid    = instr_valid & (state_q == RUN) & ~reset;
    int_req  = mst_mie_q & (|pending) & valid;
    exc_code = 5'd11;
    exc      = 1'b0;
    if (illegal_in || (csr_op != 2'b00 && (!csr_impl || csr_addr == 12'h344))) begin
      exc_code = 5'd2;
      exc      = 1'b1;
    end else if (is_ebreak) begin
      exc_code = 5'd3;
      exc      = 1'b1;
    end else if (is_ecall) begin
      exc      = 1'b1;
    end
    exc        = exc & valid & ~int_req;
    trap       = int_req | exc;
    cause_code = int_req ? int_code : exc_code;
    retire     = valid & ~trap;
    csr_we     = retire & (csr_op != 2'b00);
    mret_ok    = retire & is_mret;
    wfi_ok     = retire & is_wfi;
  end

  always_comb begin
    trap_pc = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (int_req && mtvec_q[0]) trap_pc = {mtvec_q[31:2], 2'b00} + {25'b0, int_code, 2'b00};
`endif
  end

  assign trap_taken     = trap;
  assign redirect_valid = trap | mret_ok;
  assign redirect_pc    = trap ? trap_pc : (mret_ok ? mepc_q : next_pc);

  // Architectural state next values.
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = retire ? minstret_q + 64'd1 : minstret_q;
    if (csr_we) begin
      // A write to either counter half replaces that cycle's increment.
      case (csr_addr)
        12'h300: begin
          mst_mie_d  = csr_new[3];
          mst_mpie_d = csr_new[7];
        end
        12'h304: mie_d      = csr_new & INT_MASK;
        12'h305: mtvec_d    = csr_new & MTVEC_MASK;
        12'h341: mepc_d     = csr_new & 32'hFFFF_FFFC;
        12'h342: mcause_d   = csr_new;
        12'hB00: mcycle_d   = {mcycle_q[63:32], csr_new};
        12'hB80: mcycle_d   = {csr_new, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], csr_new};
        12'hB82: minstret_d = {csr_new, minstret_q[31:0]};
        default: ;
      endcase
    end
    if (trap) begin
      mepc_d     = instr_pc & 32'hFFFF_FFFC;
      mcause_d   = {int_req, 26'b0, cause_code};
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_ok) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC & MTVEC_MASK;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Sleep FSM: state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Sleep FSM: next state. Wake ignores mstatus.MIE so a masked interrupt
  // still resumes execution at the instruction after WFI.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (wfi_ok) state_d = SLEEP;
      SLEEP:   if (|pending) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Sleep FSM: outputs.
  always_comb begin
    stall = (state_q == SLEEP) & ~reset;
  end

endmodule

// File: tb/tb_trap_csr_unit.sv
module tb_trap_csr_unit;

  localparam logic [31:0] RST_VEC = 32'h0000_0200;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] MTVEC_EXP = 32'h0000_1001;
  localparam logic [31:0] IRQ2_PC   = 32'h0000_1048;
`else
  localparam logic [31:0] MTVEC_EXP = 32'h0000_1000;
  localparam logic [31:0] IRQ2_PC   = 32'h0000_1000;
`endif

  logic        clock = 1'b0, reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_pc = '0, next_pc = '0;
  logic        is_ecall = 1'b0, is_ebreak = 1'b0, is_mret = 1'b0, is_wfi = 1'b0, illegal_in = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        msip = 1'b0, mtip = 1'b0, meip = 1'b0;
  logic [3:0]  irq = '0;
  logic        trap_taken, redirect_valid, stall;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  trap_csr_unit #(.NUM_IRQ(4), .RESET_MTVEC(RST_VEC)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .next_pc(next_pc), .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
    .is_wfi(is_wfi), .illegal_in(illegal_in), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .msip(msip), .mtip(mtip), .meip(meip),
    .irq(irq), .trap_taken(trap_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid = 0; instr_pc = 0; next_pc = 0;
    is_ecall = 0; is_ebreak = 0; is_mret = 0; is_wfi = 0; illegal_in = 0;
    csr_addr = 0; csr_op = 0; csr_wdata = 0;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_op = 2'b00;
    csr_addr = a;
    #1;
  endtask

  task automatic csr_instr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    instr_valid = 1; instr_pc = 32'h80; next_pc = 32'h84;
    csr_addr = a; csr_op = op; csr_wdata = d;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    instr_valid = 1; is_ecall = 1;
    step();
    #1;
    n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL rst_trap: got %b exp 0", trap_taken); end
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %b exp 0", redirect_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", stall); end
    step();
    reset = 0; instr_valid = 0;
    #1;
    n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL novalid_trap: got %b exp 0", trap_taken); end
    clear_inputs();
    rd(12'h305);
    n_checks++; if (csr_rdata !== RST_VEC) begin n_fail++; $display("FAIL rst_mtvec: got %h exp %h", csr_rdata, RST_VEC); end
    rd(12'hB00);
    n_checks++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL mcycle0: got %h exp 0", csr_rdata); end
    rd(12'h300);
    n_checks++; if (csr_rdata !== 32'h1800) begin n_fail++; $display("FAIL rst_mstatus: got %h exp 1800", csr_rdata); end
    for (int k = 1; k <= 3; k++) begin
      step();
      rd(12'hB00);
      n_checks++; if (csr_rdata !== 32'(k)) begin n_fail++; $display("FAIL mcycle_count: got %h exp %h", csr_rdata, k); end
    end
  endtask

  task automatic test_msi_mret();
    csr_instr(12'h300, 2'b01, 32'h8);
    csr_instr(12'h304, 2'b01, 32'h8);
    msip = 1; instr_valid = 1; instr_pc = 32'h100; next_pc = 32'h104;
    #1;
    n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL msi_trap: got %b exp 1", trap_taken); end
    n_checks++; if (redirect_pc !== RST_VEC) begin n_fail++; $display("FAIL msi_vec: got %h exp %h", redirect_pc, RST_VEC); end
    step();
    msip = 0; clear_inputs();
    rd(12'h341);
    n_checks++; if (csr_rdata !== 32'h100) begin n_fail++; $display("FAIL msi_mepc: got %h exp 100", csr_rdata); end
    rd(12'h342);
    n_checks++; if (csr_rdata !== 32'h8000_0003) begin n_fail++; $display("FAIL msi_mcause: got %h exp 80000003", csr_rdata); end
    rd(12'h300);
    n_checks++; if (csr_rdata !== 32'h1880) begin n_fail++; $display("FAIL msi_mstatus: got %h exp 1880", csr_rdata); end
    instr_valid = 1; is_mret = 1; instr_pc = 32'h200; next_pc = 32'h204;
    #1;
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin n_fail++; $display("FAIL mret_redirect: got %b/%h exp 1/100", redirect_valid, redirect_pc); end
    step();
    clear_inputs();
    rd(12'h300);
    n_checks++; if (csr_rdata !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h exp 1888", csr_rdata); end
  endtask

  task automatic test_int_priority();
    csr_instr(12'hB02, 2'b01, 32'h50);
    csr_instr(12'h304, 2'b01, 32'h888);
    rd(12'hB02);
    n_checks++; if (csr_rdata !== 32'h51) begin n_fail++; $display("FAIL minstret_pre: got %h exp 51", csr_rdata); end
    meip = 1; mtip = 1; instr_valid = 1; is_ecall = 1; instr_pc = 32'h300; next_pc = 32'h304;
    #1;
    n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL prio_trap: got %b exp 1", trap_taken); end
    step();
    meip = 0; mtip = 0; clear_inputs();
    rd(12'h342);
    n_checks++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL prio_mcause: got %h exp 8000000b", csr_rdata); end
    rd(12'hB02);
    n_checks++; if (csr_rdata !== 32'h51) begin n_fail++; $display("FAIL prio_minstret: got %h exp 51", csr_rdata); end
    rd(12'h341);
    n_checks++; if (csr_rdata !== 32'h300) begin n_fail++; $display("FAIL prio_mepc: got %h exp 300", csr_rdata); end
  endtask

  task automatic test_vectored();
    csr_instr(12'h305, 2'b01, 32'h1001);
    rd(12'h305);
    n_checks++; if (csr_rdata !== MTVEC_EXP) begin n_fail++; $display("FAIL mtvec_wr: got %h exp %h", csr_rdata, MTVEC_EXP); end
    csr_instr(12'h304, 2'b01, 32'h0004_0000);
    csr_instr(12'h300, 2'b10, 32'h8);
    irq = 4'b0100; instr_valid = 1; instr_pc = 32'h400; next_pc = 32'h404;
    #1;
    n_checks++; if (trap_taken !== 1'b1 || redirect_pc !== IRQ2_PC) begin n_fail++; $display("FAIL irq2_vec: got %b/%h exp 1/%h", trap_taken, redirect_pc, IRQ2_PC); end
    step();
    irq = 0; clear_inputs();
    rd(12'h342);
    n_checks++; if (csr_rdata !== 32'h8000_0012) begin n_fail++; $display("FAIL irq2_mcause: got %h exp 80000012", csr_rdata); end
    instr_valid = 1; is_ecall = 1; instr_pc = 32'h404; next_pc = 32'h408;
    #1;
    n_checks++; if (redirect_pc !== 32'h1000) begin n_fail++; $display("FAIL exc_base: got %h exp 1000", redirect_pc); end
    step();
    clear_inputs();
    rd(12'h342);
    n_checks++; if (csr_rdata !== 32'hB) begin n_fail++; $display("FAIL ecall_mcause: got %h exp b", csr_rdata); end
  endtask

  task automatic test_wfi();
    csr_instr(12'h304, 2'b01, 32'h80);
    instr_valid = 1; is_wfi = 1; instr_pc = 32'h500; next_pc = 32'h504;
    #1;
    n_checks++; if (trap_taken !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL wfi_retire: got %b/%b exp 0/0", trap_taken, redirect_valid); end
    step();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      instr_valid = 1; is_ecall = 1;
      #1;
      n_checks++; if (stall !== 1'b1 || trap_taken !== 1'b0) begin n_fail++; $display("FAIL sleep_hold: got %b/%b exp 1/0", stall, trap_taken); end
      step();
    end
    clear_inputs();
    mtip = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wake_edge: got %b exp 1", stall); end
    step();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL woke: got %b exp 0", stall); end
    instr_valid = 1; instr_pc = 32'h504; next_pc = 32'h508;
    #1;
    n_checks++; if (trap_taken !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h508) begin n_fail++; $display("FAIL resume: got %b/%b/%h exp 0/0/508", trap_taken, redirect_valid, redirect_pc); end
    step();
    mtip = 0; clear_inputs();
  endtask

  task automatic test_counters_illegal();
    csr_instr(12'hB80, 2'b01, 32'hFFFF_FFFF);
    csr_instr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00);
    n_checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_lo_max: got %h exp ffffffff", csr_rdata); end
    rd(12'hB80);
    n_checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_hi_max: got %h exp ffffffff", csr_rdata); end
    step();
    rd(12'hB00);
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mcycle_lo_wrap: got %h exp 0", csr_rdata); end
    rd(12'hB80);
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mcycle_hi_wrap: got %h exp 0", csr_rdata); end
    instr_valid = 1; csr_addr = 12'h7C0; csr_op = 2'b01; csr_wdata = 32'h1234; instr_pc = 32'h600;
    #1;
    n_checks++; if (trap_taken !== 1'b1 || redirect_pc !== 32'h1000) begin n_fail++; $display("FAIL illegal_trap: got %b/%h exp 1/1000", trap_taken, redirect_pc); end
    step();
    clear_inputs();
    rd(12'h342);
    n_checks++; if (csr_rdata !== 32'h2) begin n_fail++; $display("FAIL illegal_mcause: got %h exp 2", csr_rdata); end
    instr_valid = 1; is_ecall = 1; csr_addr = 12'h305; csr_op = 2'b01; csr_wdata = 32'h8000; instr_pc = 32'h604;
    step();
    clear_inputs();
    rd(12'h305);
    n_checks++; if (csr_rdata !== MTVEC_EXP) begin n_fail++; $display("FAIL discard_wr: got %h exp %h", csr_rdata, MTVEC_EXP); end
    instr_valid = 1; is_ebreak = 1; csr_addr = 12'h344; csr_op = 2'b10; csr_wdata = 32'h8; instr_pc = 32'h608;
    step();
    clear_inputs();
    rd(12'h342);
    n_checks++; if (csr_rdata !== 32'h2) begin n_fail++; $display("FAIL mip_write: got %h exp 2", csr_rdata); end
    rd(12'h344);
    n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mip_ro: got %h exp 0", csr_rdata); end
  endtask

  task automatic test_sleep_reset();
    instr_valid = 1; is_wfi = 1; instr_pc = 32'h700; next_pc = 32'h704;
    step();
    clear_inputs();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sr_sleep: got %b exp 1", stall); end
    reset = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sr_during: got %b exp 0", stall); end
    step();
    reset = 0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sr_after: got %b exp 0", stall); end
    rd(12'h305);
    n_checks++; if (csr_rdata !== RST_VEC) begin n_fail++; $display("FAIL sr_mtvec: got %h exp %h", csr_rdata, RST_VEC); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_msi_mret();
    test_int_priority();
    test_vectored();
    test_wfi();
    test_counters_illegal();
    test_sleep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
